fft_agu: RTL

FFT_AGU -- requirements
Module: fft_agu

---
 rtl/fft_agu.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fft_agu.sv
// -----------------------------------------------------------------------------
// fft_agu -- address generation unit for an in-place, ping-pong 64-point
// radix-2 FFT. One pass runs six levels of 32 butterflies each. Operands are
// read from bank bank_sel and results are written to bank ~bank_sel. After the
// last butterfly of a level is issued, the unit idles for WR_LAT cycles so that
// every result of that level lands before the next level starts reading.
//
// Ports
//   clk              single clock, rising edge
//   reset            asynchronous, active-high
//   start            begin one FFT pass (only honoured while idle)
//   busy             high whenever a pass is in progress (not IDLE)
//   done             one-cycle pulse after the last write of level 5
//   level            current FFT level 0..5
//   bank_sel         RAM bank being read; the write bank is its complement
//   read_adr_a/b     butterfly operand addresses (read bank)
//   twiddle_address  twiddle ROM address, aligned with read_adr_a/b
//   write_adr_a/b    result addresses (write bank), read addresses delayed
//   write_en         result write strobe, issue flag delayed by WR_LAT
// -----------------------------------------------------------------------------
module fft_agu #(
    parameter int BFLY_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [2:0] level,
    output logic       bank_sel,
    output logic [5:0] read_adr_a,
    output logic [5:0] read_adr_b,
    output logic [4:0] twiddle_address,
    output logic [5:0] write_adr_a,
    output logic [5:0] write_adr_b,
    output logic       write_en
);

    // One cycle of RAM/ROM read latency ahead of the butterfly itself.
    localparam int WR_LAT = BFLY_LAT + 1;
    localparam logic [3:0] FLUSH_LAST = 4'(WR_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] j_q, j_d;
    logic [2:0] level_q, level_d;
    logic       bank_q, bank_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    logic       busy_q, done_q;

    logic       issue;

    logic [5:0] wr_a_pipe_q [WR_LAT];
    logic [5:0] wr_b_pipe_q [WR_LAT];
    logic       vld_pipe_q  [WR_LAT];

    // 6-bit rotate-left: the upper half of the doubled word shifted left.
    function automatic logic [5:0] rotl6(input logic [5:0] x, input logic [2:0] sh);
        logic [11:0] dbl;
        dbl = {x, x} << sh;
        return dbl[11:6];
    endfunction

    // Keep only the top 'lvl' bits of j: level 0 -> 0, level 5 -> j.
    function automatic logic [4:0] twiddle(input logic [4:0] jj, input logic [2:0] lvl);
        logic [4:0] mask;
        mask = 5'b11111 << (3'd5 - lvl);
        return jj & mask;
    endfunction

    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        level_d     = level_q;
        bank_d      = bank_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    j_d     = 5'd0;
                end
            end
            S_RUN: begin
                if (j_q == 5'd31) begin
                    state_d     = S_FLUSH;
                    j_d         = 5'd0;
                    flush_cnt_d = 4'd0;
                end else begin
                    j_d = j_q + 5'd1;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    if (level_q == 3'd5) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        level_d = level_q + 3'd1;
                        bank_d  = ~bank_q;
                        j_d     = 5'd0;
                    end
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                level_d = 3'd0;
                j_d     = 5'd0;
                bank_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state; busy/done are registered decodes of the next state so
    // they line up exactly with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            j_q         <= 5'd0;
            level_q     <= 3'd0;
            bank_q      <= 1'b0;
            flush_cnt_q <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            level_q     <= level_d;
            bank_q      <= bank_d;
            flush_cnt_q <= flush_cnt_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign issue = (state_q == S_RUN);

    always_comb begin
        read_adr_a      = 6'd0;
        read_adr_b      = 6'd0;
        twiddle_address = 5'd0;
        if (issue) begin
            read_adr_a      = rotl6({j_q, 1'b0}, level_q);
            read_adr_b      = rotl6({j_q, 1'b1}, level_q);
            twiddle_address = twiddle(j_q, level_q);
        end
    end

    // Write-side delay line: stage 0 captures the issue, stage WR_LAT-1 drives
    // the write port. Cleared on reset so an aborted pass writes nothing more.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WR_LAT; i++) begin
                wr_a_pipe_q[i] <= 6'd0;
                wr_b_pipe_q[i] <= 6'd0;
                vld_pipe_q[i]  <= 1'b0;
            end
        end else begin
            wr_a_pipe_q[0] <= read_adr_a;
            wr_b_pipe_q[0] <= read_adr_b;
            vld_pipe_q[0]  <= issue;
            for (int i = 1; i < WR_LAT; i++) begin
                wr_a_pipe_q[i] <= wr_a_pipe_q[i-1];
                wr_b_pipe_q[i] <= wr_b_pipe_q[i-1];
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign level       = level_q;
    assign bank_sel    = bank_q;
    assign write_adr_a = wr_a_pipe_q[WR_LAT-1];
    assign write_adr_b = wr_b_pipe_q[WR_LAT-1];
    assign write_en    = vld_pipe_q[WR_LAT-1];

endmodule
